bool_truth_table_sweeper: RTL and testbench
===========================================

BOOL_TRUTH_TABLE_SWEEPER -- requirements
Module: bool_truth_table_sweeper

Interface
REQ-001 The module SHALL have exactly one parameter: SETTLE, default 1, the number of extra hold cycles per input vector before sampling (legal range 0..15).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a sweep; acted on only while idle.
REQ-005 f_in  input  1  output of the external 4-input boolean expression under test.
REQ-006 a, b, c, d  output  1 each  registered stimulus driven to the expression under test.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  one-cycle pulse marking sweep completion.
REQ-009 truth_table  output  16  bit i = sampled f_in for vector i.
REQ-010 minterm_count  output  5  number of vectors with f_in=1 (0..16).
REQ-011 any_true  output  1  high when minterm_count is nonzero.
REQ-012 first_true  output  4  lowest vector index with f_in=1; 0 when none.

Function
REQ-013 The FSM SHALL have two states: IDLE and SWEEP.
REQ-014 In IDLE, start=1 on a rising edge SHALL set state=SWEEP, busy=1, idx=0, and clear truth_table, minterm_count, any_true and first_true.
REQ-015 start SHALL be ignored in SWEEP; start held high after completion SHALL begin a new sweep on the first IDLE edge.
REQ-016 Vector mapping SHALL be {a,b,c,d} = idx[3:0], with a as MSB.
REQ-017 Each vector SHALL be held for exactly SETTLE+1 cycles; f_in SHALL be sampled on the edge that ends the hold, then idx SHALL increment.
REQ-018 On each sample with f_in=1: set truth_table[idx]; increment minterm_count; if any_true was 0, set first_true=idx and any_true=1.
REQ-019 On the sample for idx=15: state=IDLE, busy=0, done=1 for exactly one cycle; idx SHALL NOT wrap into a 17th sample.
REQ-020 done SHALL rise 16*(SETTLE+1) edges after the start-accept edge.
REQ-021 Results SHALL hold stable in IDLE until the next accepted start.
REQ-022 a..d SHALL hold their last value (1,1,1,1) in IDLE after a sweep.
REQ-023 minterm_count SHALL be 5 bits so that the value 16 does not overflow.

Reset
REQ-024 With rst_n=0 at an edge: state=IDLE, idx=0, settle counter=0, a=b=c=d=0, busy=0, done=0, truth_table=0, minterm_count=0, any_true=0, first_true=0.
REQ-025 Reset mid-sweep SHALL abort the sweep with no done pulse; start is ignored while rst_n=0.

Structure
REQ-026 A shared package bool_sweep_pkg SHALL hold the state enum (IDLE, SWEEP), the constant NUM_VECTORS=16, and the vector index width 4.
REQ-027 One sub-module, bool_sweep_settle_cnt, SHALL implement the per-vector hold counter and its sample-strobe output; everything else stays in the top module.

Verification
REQ-028 Bench drives f_in = abc + a'c' + d, SETTLE=1, start pulse -> done at +32 cycles; truth_table=0xEABB, minterm_count=11, first_true=0, any_true=1.
REQ-029 f_in = abc'd + ab'cd + abc' + ac, SETTLE=0 -> done at +16 cycles; truth_table=0xFC00, minterm_count=6, first_true=10.
REQ-030 f_in tied 0 -> truth_table=0x0000, minterm_count=0, any_true=0, first_true=0; f_in tied 1 -> 0xFFFF, count 16, first_true=0.
REQ-031 start re-pulsed at cycles 5 and 20 of a SETTLE=1 sweep -> ignored; exactly one done pulse, at +32 cycles.
REQ-032 rst_n=0 for one cycle at cycle 10 of a sweep -> all outputs at reset values next cycle, no done; a fresh start then completes normally.
REQ-033 start held high continuously with SETTLE=3 -> back-to-back sweeps, done every 65 cycles (64 sweep + 1 IDLE), results cleared at each restart.

Source files
------------

// File: rtl/bool_sweep_pkg.sv
// -----------------------------------------------------------------------------
// bool_sweep_pkg
// Shared definitions for the boolean truth-table sweeper:
//   state_t      - sweep controller states (IDLE, SWEEP)
//   NUM_VECTORS  - number of input vectors of a 4-input expression (16)
//   IDX_W        - width of the vector index (4)
//   SETTLE_W     - width of the per-vector hold counter (covers SETTLE 0..15)
//   CNT_W        - width of the minterm counter (must hold the value 16)
//   LAST_IDX     - index of the final vector of a sweep
// -----------------------------------------------------------------------------
package bool_sweep_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int SETTLE_W    = 4;
    localparam int CNT_W       = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/bool_sweep_settle_cnt.sv
// -----------------------------------------------------------------------------
// bool_sweep_settle_cnt
// Per-vector hold counter. While enabled it counts 0..SETTLE and raises the
// sample strobe on the last cycle of each hold, so every vector is presented
// for exactly SETTLE+1 cycles before f_in is captured.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   i_clear   in   restart the hold count from zero (sweep accepted)
//   i_enable  in   count only while a sweep is in progress
//   o_sample  out  high in the cycle whose closing edge samples f_in
// -----------------------------------------------------------------------------
module bool_sweep_settle_cnt
    import bool_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_sample
);

    // SETTLE is limited to 0..15; the counter is sized for that range.
    localparam logic [SETTLE_W-1:0] LP_HOLD_LAST = SETTLE_W'(SETTLE);

    logic [SETTLE_W-1:0] r_cnt;
    logic                w_at_last;

    assign w_at_last = (r_cnt == LP_HOLD_LAST);
    assign o_sample  = i_enable & w_at_last;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            // Wrap on the sampling cycle so the next vector starts a fresh hold.
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bool_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// bool_truth_table_sweeper
// Drives all 16 input combinations {a,b,c,d} into an external 4-input
// boolean expression, samples its output f_in after each vector has settled,
// and builds the truth table plus summary statistics.
//
// Parameters
//   SETTLE         extra hold cycles per vector before sampling (0..15)
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   synchronous active-low reset
//   start          in   request a sweep (only acted on in IDLE)
//   f_in           in   output of the expression under test
//   a, b, c, d     out  registered stimulus, a is the MSB of the vector index
//   busy           out  sweep in progress
//   done           out  one-cycle pulse when the last vector is sampled
//   truth_table    out  bit i = sampled f_in for vector i
//   minterm_count  out  number of vectors with f_in = 1 (0..16)
//   any_true       out  minterm_count is nonzero
//   first_true     out  lowest vector index with f_in = 1 (0 when none)
// -----------------------------------------------------------------------------
module bool_truth_table_sweeper
    import bool_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  minterm_count,
    output logic        any_true,
    output logic [3:0]  first_true
);

    state_t                 r_state;
    state_t                 w_state_next;

    logic [IDX_W-1:0]       r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic [NUM_VECTORS-1:0] r_truth;
    logic [CNT_W-1:0]       r_count;
    logic                   r_any;
    logic [IDX_W-1:0]       r_first;

    logic                   w_sample;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_sweeping;
    logic                   w_hit_now;
    logic [NUM_VECTORS-1:0] w_hit;

    assign w_sweeping = (r_state == SWEEP);
    assign w_hit_now  = w_sample & f_in;

    // -------------------------------------------------------------------------
    // Per-vector hold counter
    // -------------------------------------------------------------------------
    bool_sweep_settle_cnt #(
        .SETTLE   (SETTLE)
    ) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_accept),
        .i_enable (w_sweeping),
        .o_sample (w_sample)
    );

    // -------------------------------------------------------------------------
    // Controller: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Controller: next state and control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = SWEEP;
                end
            end
            SWEEP: begin
                // start is deliberately not looked at here.
                if (w_sample && (r_idx == LAST_IDX)) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Truth-table bit set enables: one decoded enable per vector.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VECTORS; gi++) begin : g_hit
            assign w_hit[gi] = w_hit_now & (r_idx == IDX_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Datapath: stimulus index, results and status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_truth <= '0;
            r_count <= '0;
            r_any   <= 1'b0;
            r_first <= '0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_idx   <= '0;
                r_busy  <= 1'b1;
                r_truth <= '0;
                r_count <= '0;
                r_any   <= 1'b0;
                r_first <= '0;
            end else if (w_sample) begin
                r_truth <= r_truth | w_hit;
                if (f_in) begin
                    r_count <= r_count + 1'b1;
                    if (!r_any) begin
                        r_first <= r_idx;
                        r_any   <= 1'b1;
                    end
                end
                // The final vector stays on a..d after the sweep; no wrap.
                if (w_last) begin
                    r_busy <= 1'b0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign a             = r_idx[3];
    assign b             = r_idx[2];
    assign c             = r_idx[1];
    assign d             = r_idx[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign truth_table   = r_truth;
    assign minterm_count = r_count;
    assign any_true      = r_any;
    assign first_true    = r_first;

endmodule

// File: tb/tb_bool_truth_table_sweeper.sv
module tb_bool_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Three instances cover SETTLE = 0, 1 and 3.
    logic        start0, start1, start3;
    logic        f0, f1, f3;
    int          m0, m1, m3;
    logic        a0, b0, c0, d0, busy0, done0, any0;
    logic        a1, b1, c1, d1, busy1, done1, any1;
    logic        a3, b3, c3, d3, busy3, done3, any3;
    logic [15:0] tt0, tt1, tt3;
    logic [4:0]  cnt0, cnt1, cnt3;
    logic [3:0]  first0, first1, first3;

    int n_checks = 0;
    int n_errors = 0;

    // Expression models: 0 = const 0, 1 = const 1,
    // 2 = abc + a'c' + d, 3 = abc'd + ab'cd + abc' + ac
    function automatic logic fexpr(input int mode, input logic a, input logic b,
                                   input logic c, input logic d);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (a & b & c) | (~a & ~c) | d;
            3:       return (a & b & ~c & d) | (a & ~b & c & d) | (a & b & ~c) | (a & c);
            default: return 1'b0;
        endcase
    endfunction

    assign f0 = fexpr(m0, a0, b0, c0, d0);
    assign f1 = fexpr(m1, a1, b1, c1, d1);
    assign f3 = fexpr(m3, a3, b3, c3, d3);

    bool_truth_table_sweeper #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .truth_table(tt0), .minterm_count(cnt0), .any_true(any0), .first_true(first0)
    );

    bool_truth_table_sweeper #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .truth_table(tt1), .minterm_count(cnt1), .any_true(any1), .first_true(first1)
    );

    bool_truth_table_sweeper #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f3),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .truth_table(tt3), .minterm_count(cnt3), .any_true(any3), .first_true(first3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return done0;
            1:       return done1;
            default: return done3;
        endcase
    endfunction

    // Ticks until the selected instance pulses done, bounded by limit.
    task automatic wait_done(input int which, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_of(which) && n < limit);
    endtask

    int n;
    int ndone;
    int done_at;

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
        m0 = 0; m1 = 0; m3 = 0;
        tick();
        tick();

        // ---------------- Reset state ----------------
        chk("rst_busy",  32'(busy1), 32'h0);
        chk("rst_done",  32'(done1), 32'h0);
        chk("rst_abcd",  32'({a1, b1, c1, d1}), 32'h0);
        chk("rst_tt",    32'(tt1), 32'h0);
        chk("rst_cnt",   32'(cnt1), 32'h0);
        chk("rst_any",   32'(any1), 32'h0);
        chk("rst_first", 32'(first1), 32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- abc + a'c' + d, SETTLE=1 ----------------
        m1 = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("A_busy_accept", 32'(busy1), 32'h1);
        chk("A_abcd_accept", 32'({a1, b1, c1, d1}), 32'h0);
        wait_done(1, 100, n);
        chk("A_done_latency", 32'(n), 32'd32);
        chk("A_tt",    32'(tt1), 32'hEABB);
        chk("A_cnt",   32'(cnt1), 32'd11);
        chk("A_first", 32'(first1), 32'd0);
        chk("A_any",   32'(any1), 32'h1);
        chk("A_busy_end", 32'(busy1), 32'h0);
        chk("A_abcd_end", 32'({a1, b1, c1, d1}), 32'hF);
        tick();
        chk("A_done_pulse", 32'(done1), 32'h0);
        chk("A_tt_hold",    32'(tt1), 32'hEABB);
        chk("A_abcd_hold",  32'({a1, b1, c1, d1}), 32'hF);

        // ---------------- abc'd + ab'cd + abc' + ac, SETTLE=0 ----------------
        m0 = 3;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done(0, 100, n);
        chk("B_done_latency", 32'(n), 32'd16);
        chk("B_tt",    32'(tt0), 32'hFC00);
        chk("B_cnt",   32'(cnt0), 32'd6);
        chk("B_first", 32'(first0), 32'd10);
        chk("B_any",   32'(any0), 32'h1);

        // ---------------- f_in tied 1, then tied 0 ----------------
        m0 = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done(0, 100, n);
        chk("C1_done_latency", 32'(n), 32'd16);
        chk("C1_tt",    32'(tt0), 32'hFFFF);
        chk("C1_cnt",   32'(cnt0), 32'd16);
        chk("C1_first", 32'(first0), 32'd0);
        chk("C1_any",   32'(any0), 32'h1);
        m0 = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("C0_tt_cleared",  32'(tt0), 32'h0);
        chk("C0_cnt_cleared", 32'(cnt0), 32'h0);
        wait_done(0, 100, n);
        chk("C0_done_latency", 32'(n), 32'd16);
        chk("C0_tt",    32'(tt0), 32'h0);
        chk("C0_cnt",   32'(cnt0), 32'd0);
        chk("C0_any",   32'(any0), 32'h0);
        chk("C0_first", 32'(first0), 32'd0);

        // ---------------- start re-pulsed during sweep ----------------
        m1 = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        ndone = 0;
        done_at = -1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            start1 = (k == 5 || k == 20);
            if (done1) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
        end
        start1 = 1'b0;
        chk("D_done_count", 32'(ndone), 32'd1);
        chk("D_done_at",    32'(done_at), 32'd32);
        chk("D_tt",         32'(tt1), 32'hEABB);
        chk("D_busy",       32'(busy1), 32'h0);

        // ---------------- reset mid-sweep ----------------
        m1 = 1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("E_busy_mid", 32'(busy1), 32'h1);
        rst_n = 1'b0;
        start1 = 1'b1;       // must be ignored while in reset
        tick();
        rst_n = 1'b1;
        start1 = 1'b0;
        chk("E_busy",  32'(busy1), 32'h0);
        chk("E_done",  32'(done1), 32'h0);
        chk("E_abcd",  32'({a1, b1, c1, d1}), 32'h0);
        chk("E_tt",    32'(tt1), 32'h0);
        chk("E_cnt",   32'(cnt1), 32'h0);
        chk("E_any",   32'(any1), 32'h0);
        chk("E_first", 32'(first1), 32'h0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done1) ndone++;
        end
        chk("E_no_done", 32'(ndone), 32'd0);
        chk("E_idle_busy", 32'(busy1), 32'h0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done(1, 100, n);
        chk("E_restart_latency", 32'(n), 32'd32);
        chk("E_restart_tt",  32'(tt1), 32'hFFFF);
        chk("E_restart_cnt", 32'(cnt1), 32'd16);

        // ---------------- start held high, SETTLE=3 ----------------
        m3 = 2;
        start3 = 1'b1;
        tick();
        chk("F_busy_accept", 32'(busy3), 32'h1);
        ndone = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (done3) begin
                ndone++;
                chk("F_done_at", 32'(k), 32'(64 + 65 * (ndone - 1)));
                chk("F_tt",  32'(tt3), 32'hEABB);
                chk("F_cnt", 32'(cnt3), 32'd11);
            end
            if (k == 65 || k == 130) begin
                chk("F_restart_busy", 32'(busy3), 32'h1);
                chk("F_restart_tt",   32'(tt3), 32'h0);
                chk("F_restart_cnt",  32'(cnt3), 32'h0);
            end
        end
        chk("F_done_count", 32'(ndone), 32'd3);
        start3 = 1'b0;
        n = 0;
        while (busy3 && n < 100) begin
            tick();
            n++;
        end
        chk("F_final_idle", 32'(busy3), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
